mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that merges the fetch and load/store ports onto one memory port.
// It places store lanes, extracts load lanes and allows one outstanding access at a time.
package isa_types;
  parameter int XLEN = 32;
  typedef enum logic [1:0] {
    write_byte     = 2'd0,
    write_halfword = 2'd1,
    write_word     = 2'd2
  } write_width_t;
endpackage

module mem_port_arbiter #(
  parameter int XLEN = isa_types::XLEN
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     if_req,
  input  logic [XLEN-1:0]          if_addr,
  output logic                     if_gnt,
  output logic                     if_rvalid,
  output logic [XLEN-1:0]          if_rdata,
  input  logic                     ls_req,
  input  logic                     ls_we,
  input  isa_types::write_width_t  ls_width,
  input  logic [XLEN-1:0]          ls_addr,
  input  logic [XLEN-1:0]          ls_wdata,
  output logic                     ls_gnt,
  output logic                     ls_rvalid,
  output logic [XLEN-1:0]          ls_rdata,
  output logic                     ls_misaligned,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [XLEN-1:0]          mem_addr,
  output logic [XLEN-1:0]          mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     mem_ready,
  input  logic                     mem_rvalid,
  input  logic [XLEN-1:0]          mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  // What is needed to route and align the read data when it comes back.
  typedef struct packed {
    logic                    owner_ls;
    logic [1:0]              off;
    isa_types::write_width_t width;
  } rsp_ctx_t;

  state_t          state;
  rsp_ctx_t        rsp;
  logic            prefer_ls;
  logic            sel_ls, sel_if, ls_misal;
  logic [3:0]      lane_be, base_be;
  logic [XLEN-1:0] lane_wdata, rd_shift, ld_data;

  always_comb begin
    ls_misal = (ls_width == isa_types::write_halfword && ls_addr[0]) ||
               (ls_width == isa_types::write_word && ls_addr[1:0] != 2'b00);
    sel_ls   = ls_req && (!if_req || prefer_ls);
    sel_if   = if_req && !sel_ls;
    if_gnt        = (state == IDLE) && !reset && sel_if;
    ls_gnt        = (state == IDLE) && !reset && sel_ls;
    ls_misaligned = ls_gnt && ls_misal;

    case (ls_width)
      isa_types::write_byte:     base_be = 4'b0001;
      isa_types::write_halfword: base_be = 4'b0011;
      default:                   base_be = 4'b1111;
    endcase
    lane_be    = base_be << ls_addr[1:0];
    lane_wdata = ls_wdata << {ls_addr[1:0], 3'b000};

    rd_shift = mem_rdata >> {rsp.off, 3'b000};
    case (rsp.width)
      isa_types::write_byte:     ld_data = {{(XLEN-8){1'b0}}, rd_shift[7:0]};
      isa_types::write_halfword: ld_data = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
      default:                   ld_data = rd_shift;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      prefer_ls <= 1'b1;
      rsp       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'b0000;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (if_gnt) begin
            prefer_ls    <= 1'b1;
            rsp.owner_ls <= 1'b0;
            mem_req      <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= {if_addr[XLEN-1:2], 2'b00};
            mem_be       <= 4'b1111;
            state        <= REQ;
          end else if (ls_gnt) begin
            prefer_ls <= 1'b0;
            // A misaligned access is answered by the grant-cycle error pulse alone.
            if (!ls_misal) begin
              rsp       <= '{owner_ls: 1'b1, off: ls_addr[1:0], width: ls_width};
              mem_req   <= 1'b1;
              mem_we    <= ls_we;
              mem_addr  <= {ls_addr[XLEN-1:2], 2'b00};
              mem_be    <= lane_be;
              mem_wdata <= lane_wdata;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              ls_rvalid <= 1'b1;
              ls_rdata  <= '0;
              state     <= IDLE;
            end else begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (mem_rvalid) begin
            state <= IDLE;
            if (rsp.owner_ls) begin
              ls_rvalid <= 1'b1;
              ls_rdata  <= ld_data;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model of the
// grant, alignment and response rules, with random memory timing and random resets.
module tb_mem_port_arbiter;
  localparam int XLEN = 32;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    if_req, if_gnt, if_rvalid;
  logic [XLEN-1:0]         if_addr, if_rdata;
  logic                    ls_req, ls_we, ls_gnt, ls_rvalid, ls_misaligned;
  isa_types::write_width_t ls_width;
  logic [XLEN-1:0]         ls_addr, ls_wdata, ls_rdata;
  logic                    mem_req, mem_we, mem_ready, mem_rvalid;
  logic [XLEN-1:0]         mem_addr, mem_wdata, mem_rdata;
  logic [3:0]              mem_be;

  always #5 clock = ~clock;

  mem_port_arbiter #(.XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_width(ls_width), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .ls_misaligned(ls_misaligned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0 = free, 1 = command on the bus, 2 = read data awaited.
  int          phase;
  bit          rr_ls;
  bit          m_we, m_owner_ls;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  int          m_off, m_n;
  bit          due_if, due_ls;
  logic [31:0] last_if, last_ls;
  bit          if_pend, ls_pend;
  logic [1:0]  ls_w;
  bit          fixed_data;

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] lanes(input int off, input int n);
    logic [3:0] be;
    for (int k = 0; k < 4; k++) be[k] = (k >= off) && (k < off + n);
    return be;
  endfunction

  function automatic logic [31:0] pick(input logic [31:0] w, input int off, input int n);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = w[8*(off+k) +: 8];
    return r;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit rst);
    bit exp_ls, exp_if, exp_mis;
    chk("mem_req", mem_req, phase == 1);
    if (phase == 1) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_be", mem_be, m_be);
      chk("mem_we", mem_we, m_we);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("if_rvalid", if_rvalid, due_if);
    chk("ls_rvalid", ls_rvalid, due_ls);
    chk("if_rdata", if_rdata, last_if);
    chk("ls_rdata", ls_rdata, last_ls);
    due_if = 0;
    due_ls = 0;

    reset      = rst;
    if_req     = if_pend;
    ls_req     = ls_pend;
    ls_width   = isa_types::write_width_t'(ls_w);
    mem_ready  = ($urandom_range(0, 1) == 0);
    mem_rvalid = ($urandom_range(0, 2) == 0);
    mem_rdata  = fixed_data ? 32'hBEEF1234 : $urandom;
    #1;

    exp_ls  = !rst && phase == 0 && ls_pend && (!if_pend || rr_ls);
    exp_if  = !rst && phase == 0 && if_pend && !exp_ls;
    exp_mis = exp_ls && (ls_addr % nbytes(ls_w)) != 0;
    chk("if_gnt", if_gnt, exp_if);
    chk("ls_gnt", ls_gnt, exp_ls);
    chk("ls_misaligned", ls_misaligned, exp_mis);

    if (rst) begin
      phase = 0; rr_ls = 1; last_if = 0; last_ls = 0;
    end else if (exp_if) begin
      rr_ls = 1; if_pend = 0; phase = 1;
      m_owner_ls = 0; m_we = 0; m_be = 4'hF; m_addr = if_addr & ~32'h3;
    end else if (exp_ls) begin
      rr_ls = 0; ls_pend = 0;
      if (!exp_mis) begin
        phase = 1; m_owner_ls = 1; m_we = ls_we;
        m_off = int'(ls_addr % 4); m_n = nbytes(ls_w);
        m_addr = ls_addr - m_off;
        m_be = lanes(m_off, m_n);
        m_wdata = ls_wdata << (8 * m_off);
      end
    end else if (phase == 1 && mem_ready) begin
      if (m_we) begin
        phase = 0; due_ls = 1; last_ls = 0;
      end else phase = 2;
    end else if (phase == 2 && mem_rvalid) begin
      phase = 0;
      if (m_owner_ls) begin due_ls = 1; last_ls = pick(mem_rdata, m_off, m_n); end
      else begin due_if = 1; last_if = mem_rdata; end
    end
    @(negedge clock);
  endtask

  // Directed load/store lead-in: store byte, load halfword, misaligned store word.
  logic [31:0] d_addr  [3] = '{32'h203, 32'h102, 32'h006};
  logic [1:0]  d_width [3] = '{2'd0, 2'd1, 2'd2};
  bit          d_we    [3] = '{1'b1, 1'b0, 1'b1};
  int          d_idx = 0;

  initial begin
    reset = 1; if_req = 1; ls_req = 1; ls_we = 0; ls_w = 2'd0;
    ls_width = isa_types::write_byte; if_addr = '0; ls_addr = '0; ls_wdata = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    @(negedge clock); @(negedge clock);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_ls_gnt", ls_gnt, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);

    phase = 0; rr_ls = 1; due_if = 0; due_ls = 0; last_if = 0; last_ls = 0;
    fixed_data = 1;
    if_pend = 1; if_addr = 32'h100;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 60) fixed_data = 0;
      if (!ls_pend) begin
        if (d_idx < 3) begin
          ls_pend = 1; ls_addr = d_addr[d_idx]; ls_w = d_width[d_idx];
          ls_we = d_we[d_idx]; ls_wdata = 32'hAB; d_idx++;
        end else if (cyc >= 60 && $urandom_range(0, 2) == 0) begin
          ls_pend = 1; ls_we = $urandom_range(0, 1); ls_w = 2'($urandom_range(0, 2));
          ls_addr = $urandom & 32'h3FF; ls_wdata = $urandom;
          if ($urandom_range(0, 1) == 0) ls_addr = ls_addr & ~(32'(nbytes(ls_w)) - 1);
        end
      end
      if (!if_pend && cyc >= 60 && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_addr = $urandom;
      end
      step(cyc >= 60 && $urandom_range(0, 49) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
